// File: rtl/program_counter_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package program_counter_pkg;

    localparam int PC_ADDR_W      = 8;
    localparam int PC_STACK_DEPTH = 4;

    typedef logic [PC_ADDR_W-1:0] addr_t;

    localparam addr_t PC_RESET_ADDR = '0;

    // Source of the next PC value, listed in decreasing priority.
    typedef enum logic [2:0] {
        HOLD,
        RET,
        CALL,
        LOAD,
        BRANCH,
        INC
    } pc_sel_e;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses for call/ret; err pulses on push-when-full or pop-when-empty.
// Latency: push/pop take effect at the next clk edge; top_dat/full/empty/err are combinational from state.
// Backpressure: none; a push into a full stack is dropped, a pop from an empty stack is ignored.
//
// Ports: clk, rst_n (async active-low, flushes the stack); push/push_dat write a
// new entry; pop removes the top entry; top_dat shows the top entry (0 when empty);
// full/empty report occupancy; err flags a dropped push or an empty pop this cycle.
module pc_return_stack
    import program_counter_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W,
    parameter int DEPTH  = PC_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_dat,
    output logic [ADDR_W-1:0] top_dat,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    assign wr_idx  = IDX_W'(cnt_q);
    assign top_idx = IDX_W'(cnt_q - CNT_ONE);
    assign top_dat = empty ? '0 : mem_q[top_idx];

    // A pop in the same cycle as a push wins; the push is discarded rather than
    // being counted as an overflow.
    assign err = (pop && empty) || (push && !pop && full);

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (pop) begin
            if (!empty) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (push && !full) begin
            mem_d[wr_idx] = push_dat;
            cnt_d         = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/program_counter.sv
// Fetch-stage program counter: increment, absolute load, relative branch, stall, optional call/ret stack.
// Latency: current_instruction_address updates one edge after controls; next_input_instruction_address is same-cycle combinational.
// Backpressure: stall holds the PC and blocks all stack activity; no other flow control.
//
// Ports: clk, rst_n (async active-low); instruction_address is the load/call target;
// load, stall, branch_en (+ branch_offset, signed), call, ret select the next PC;
// current_instruction_address is the registered PC; next_input_instruction_address
// is the value it takes at the coming edge; stack_err is a sticky overflow/underflow flag.
// Build option: define PC_CALL_STACK_EN to include the return stack; otherwise call acts
// as load, ret is ignored and stack_err is tied low.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int                ADDR_W      = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(PC_RESET_ADDR),
    parameter int                STACK_DEPTH = PC_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] instruction_address,
    input  logic              load,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] current_instruction_address,
    output logic [ADDR_W-1:0] next_input_instruction_address,
    output logic              stack_err
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stk_top;
    logic              ret_sel;
    logic              call_sel;
    logic              load_sel;
    pc_sel_e           sel;

    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef PC_CALL_STACK_EN
    logic stk_full;
    logic stk_empty;
    logic stk_err_pls;
    logic stack_err_q;
    logic stack_err_d;

    // ret only redirects when there is something to pop; an empty-stack ret
    // falls through to the lower-priority controls. Any ret masks call.
    assign ret_sel  = ret && !stk_empty;
    assign call_sel = call && !ret;
    assign load_sel = load;

    pc_return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (!stall && call_sel),
        .pop      (!stall && ret),
        .push_dat (pc_inc),
        .top_dat  (stk_top),
        .full     (stk_full),
        .empty    (stk_empty),
        .err      (stk_err_pls)
    );

    always_comb begin
        stack_err_d = stack_err_q | stk_err_pls;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_err_q <= 1'b0;
        end else begin
            stack_err_q <= stack_err_d;
        end
    end

    assign stack_err = stack_err_q;
`else
    logic unused_ret;

    assign unused_ret = ret;
    assign ret_sel    = 1'b0;
    assign call_sel   = 1'b0;
    assign load_sel   = load | call;
    assign stk_top    = '0;
    assign stack_err  = 1'b0;
`endif

    always_comb begin
        sel = INC;
        if (stall) begin
            sel = HOLD;
        end else if (ret_sel) begin
            sel = RET;
        end else if (call_sel) begin
            sel = CALL;
        end else if (load_sel) begin
            sel = LOAD;
        end else if (branch_en) begin
            sel = BRANCH;
        end
    end

    // Branch sum is truncated to ADDR_W, so a negative offset is plain modular add.
    always_comb begin
        pc_d = pc_inc;
        case (sel)
            HOLD:        pc_d = pc_q;
            RET:         pc_d = stk_top;
            CALL, LOAD:  pc_d = instruction_address;
            BRANCH:      pc_d = pc_q + branch_offset;
            default:     pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign current_instruction_address    = pc_q;
    assign next_input_instruction_address = pc_d;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with a queue-based scoreboard.
// Latency: expectations are pushed just after each rising edge and checked at the falling edge.
// Backpressure: n/a.
module tb_program_counter;

`ifdef PC_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    // Control bundle bit positions: {stall, ret, call, load, branch_en}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_ST   = 5'b10000;
    localparam logic [4:0] C_RE   = 5'b01000;
    localparam logic [4:0] C_CA   = 5'b00100;
    localparam logic [4:0] C_LD   = 5'b00010;
    localparam logic [4:0] C_BR   = 5'b00001;

    typedef struct {
        string      nm;
        logic [7:0] cur;
        logic [7:0] nxt;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] instruction_address;
    logic       load;
    logic       stall;
    logic       branch_en;
    logic [7:0] branch_offset;
    logic       call;
    logic       ret;
    logic [7:0] current_instruction_address;
    logic [7:0] next_input_instruction_address;
    logic       stack_err;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    program_counter dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .instruction_address            (instruction_address),
        .load                           (load),
        .stall                          (stall),
        .branch_en                      (branch_en),
        .branch_offset                  (branch_offset),
        .call                           (call),
        .ret                            (ret),
        .current_instruction_address    (current_instruction_address),
        .next_input_instruction_address (next_input_instruction_address),
        .stack_err                      (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare every pending expectation when the outputs are stable.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                check_val(e.nm, "cur", current_instruction_address, e.cur);
                check_val(e.nm, "nxt", next_input_instruction_address, e.nxt);
                check_val(e.nm, "err", {7'd0, stack_err}, {7'd0, e.err});
            end
        end
    end

    task automatic step(input string nm, input logic [4:0] ctl, input logic [7:0] ia,
                        input logic [7:0] off, input logic [7:0] ec, input logic [7:0] en,
                        input logic ee);
        @(posedge clk);
        #1;
        stall               = ctl[4];
        ret                 = ctl[3];
        call                = ctl[2];
        load                = ctl[1];
        branch_en           = ctl[0];
        instruction_address = ia;
        branch_offset       = off;
        q.push_back('{nm, ec, en, ee});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {stall, ret, call, load, branch_en} = C_NONE;
        instruction_address = 8'h00;
        branch_offset       = 8'h00;

        #2;
        q.push_back('{"reset", 8'h00, 8'h01, 1'b0});
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Free run
        step("run1", C_NONE, 8'h00, 8'h00, 8'h01, 8'h02, 1'b0);
        step("run2", C_NONE, 8'h00, 8'h00, 8'h02, 8'h03, 1'b0);
        step("run3", C_NONE, 8'h00, 8'h00, 8'h03, 8'h04, 1'b0);

        // Wrap
        step("ld_fe", C_LD,   8'hFE, 8'h00, 8'h04, 8'hFE, 1'b0);
        step("wrap0", C_NONE, 8'h00, 8'h00, 8'hFE, 8'hFF, 1'b0);
        step("wrap1", C_NONE, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0);
        step("wrap2", C_NONE, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0);

        // Load every cycle: current lags instruction_address by one edge
        for (int i = 1; i <= 7; i++) begin
            step("ldseq", C_LD, 8'(i), 8'h00, (i == 1) ? 8'h01 : 8'(i - 1), 8'(i), 1'b0);
        end

        // Branch, stall priority, branch wrap
        step("ld_02",    C_LD,               8'h02, 8'h00, 8'h07, 8'h02, 1'b0);
        step("br_neg",   C_BR,               8'h00, 8'hFC, 8'h02, 8'hFE, 1'b0);
        step("st_ld",    C_ST | C_LD,        8'h40, 8'h00, 8'hFE, 8'hFE, 1'b0);
        step("st_rc",    C_ST | C_RE | C_CA, 8'h55, 8'h00, 8'hFE, 8'hFE, 1'b0);
        step("ld_f0",    C_LD,               8'hF0, 8'h00, 8'hFE, 8'hF0, 1'b0);
        step("br_wrap",  C_BR,               8'h00, 8'h20, 8'hF0, 8'h10, 1'b0);

        // Call / return
        step("call80", C_CA,   8'h80, 8'h00, 8'h10, 8'h80, 1'b0);
        step("idle80", C_NONE, 8'h00, 8'h00, 8'h80, 8'h81, 1'b0);
        step("idle81", C_NONE, 8'h00, 8'h00, 8'h81, 8'h82, 1'b0);
        step("ret11",  C_RE,   8'h00, 8'h00, 8'h82, STK ? 8'h11 : 8'h83, 1'b0);
        step("after",  C_NONE, 8'h00, 8'h00, STK ? 8'h11 : 8'h83, STK ? 8'h12 : 8'h84, 1'b0);

        // Five calls into a four-deep stack: the last push is dropped
        step("c20", C_CA, 8'h20, 8'h00, STK ? 8'h12 : 8'h84, 8'h20, 1'b0);
        step("c30", C_CA, 8'h30, 8'h00, 8'h20, 8'h30, 1'b0);
        step("c40", C_CA, 8'h40, 8'h00, 8'h30, 8'h40, 1'b0);
        step("c50", C_CA, 8'h50, 8'h00, 8'h40, 8'h50, 1'b0);
        step("c60", C_CA, 8'h60, 8'h00, 8'h50, 8'h60, 1'b0);
        step("ovf", C_NONE, 8'h00, 8'h00, 8'h60, 8'h61, STK);
        step("r41", C_RE, 8'h00, 8'h00, 8'h61, STK ? 8'h41 : 8'h62, STK);
        step("r31", C_RE, 8'h00, 8'h00, STK ? 8'h41 : 8'h62, STK ? 8'h31 : 8'h63, STK);
        step("r21", C_RE, 8'h00, 8'h00, STK ? 8'h31 : 8'h63, STK ? 8'h21 : 8'h64, STK);
        step("r13", C_RE, 8'h00, 8'h00, STK ? 8'h21 : 8'h64, STK ? 8'h13 : 8'h65, STK);
        step("ld37", C_LD, 8'h37, 8'h00, STK ? 8'h13 : 8'h65, 8'h37, STK);
        step("at37", C_NONE, 8'h00, 8'h00, 8'h37, 8'h38, STK);

        // Asynchronous reset pulse between edges
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        q.push_back('{"arst", 8'h00, 8'h01, 1'b0});
        ->sample_ev;
        #1 rst_n = 1'b1;

        // Counting resumes; then underflow
        step("resume", C_RE,   8'h00, 8'h00, 8'h01, 8'h02, 1'b0);
        step("undf1",  C_NONE, 8'h00, 8'h00, 8'h02, 8'h03, STK);
        step("undf2",  C_NONE, 8'h00, 8'h00, 8'h03, 8'h04, STK);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 8-bit instruction-address register for the processor fetch stage; holds the address of the instruction being fetched.
- Each clock it advances by one, or takes an absolute load, a PC-relative branch, or a stall.
- Drives the current address to instruction memory.
- Also drives the combinational next-address value that the PC will take at the coming edge.

Parameters:
- ADDR_W, 8, address width in bits; all address arithmetic is modulo 2^ADDR_W.
- RESET_ADDR, 0, value loaded into the PC on reset.
- STACK_DEPTH, 4, return-stack entries; used only with PC_CALL_STACK_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- instruction_address  input  ADDR_W  absolute target for load/call.
- load  input  1  absolute jump to instruction_address.
- stall  input  1  hold the PC unchanged.
- branch_en  input  1  PC-relative branch.
- branch_offset  input  ADDR_W  two's-complement signed offset added to the current PC.
- call  input  1  jump to instruction_address and push the return address.
- ret  input  1  pop the return address into the PC.
- current_instruction_address  output  ADDR_W  registered PC.
- next_input_instruction_address  output  ADDR_W  combinational value the PC will hold after the next edge.
- stack_err  output  1  sticky flag for stack overflow/underflow.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - current_instruction_address = RESET_ADDR.
  - Stack empty; stack_err = 0.
  - All control inputs are ignored while reset is asserted.
- Next-value selection, in strict priority order:
  1. stall: next = current.
  2. ret with stack non-empty: next = top of stack (pop).
  3. call: next = instruction_address (push current+1).
  4. load: next = instruction_address.
  5. branch_en: next = current + branch_offset.
  6. Otherwise: next = current + 1.
- next_input_instruction_address always equals the selected next value. It is purely combinational from current PC, inputs and stack top.
- Latency:
  - current_instruction_address updates one cycle after the controls are sampled.
  - next_input_instruction_address reflects input changes in the same cycle.
- Wrap-around:
  - 0xFF + 1 = 0x00.
  - Branch sums are truncated to ADDR_W bits (0x02 + 0xFC = 0xFE).
- Stack underflow: ret on empty stack sets stack_err and the PC increments normally.
- Stack overflow: call on full stack sets stack_err, the push is dropped, and the jump still occurs.
- Simultaneous call+ret: ret wins and call is ignored. If the stack is empty, the underflow rule applies.
- stall has top priority: it blocks push/pop and never sets stack_err.
- stack_err clears only on reset.
- Reset asserted mid-operation: immediate return to RESET_ADDR, the stack is flushed, and normal counting resumes on the first edge after deassertion.

Optional Feature:
- Macro: PC_CALL_STACK_EN.
- Defined: the return stack of STACK_DEPTH entries exists with the push/pop/error behaviour above.
- Undefined:
  - No stack storage is built.
  - call behaves exactly like load.
  - ret is ignored, so the PC increments unless a lower-priority control applies.
  - stack_err is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- Package program_counter_pkg:
  - ADDR_W default and the addr_t typedef (logic [ADDR_W-1:0]).
  - RESET_ADDR constant.
  - pc_sel_e enum: HOLD, RET, CALL, LOAD, BRANCH, INC.
- One sub-module, pc_return_stack: a LIFO with push/pop, top, full/empty and an err pulse. It is instantiated only under PC_CALL_STACK_EN.
- The next-value mux and PC register stay in program_counter.

Test Plan:
- Reset then free-run:
  - Release rst_n with no controls -> current goes 0x00,0x01,0x02,... each edge.
  - next_input_instruction_address is always current+1.
- Wrap: load 0xFE, then idle -> current 0xFE, 0xFF, 0x00; next shows 0x00 while current = 0xFF.
- Load sequence:
  - instruction_address = 1..7 with load every cycle -> current follows 1..7 one cycle later.
  - next equals instruction_address in the same cycle.
- Branch and stall priority:
  - At PC 0x02, branch_offset 0xFC -> current 0xFE.
  - stall + load 0x40 -> PC holds.
  - Branch wrap: PC 0xF0 + offset 0x20 -> 0x10.
- Stack (PC_CALL_STACK_EN):
  - At PC 0x10, call 0x80 -> 0x80; idle to 0x82; ret -> 0x11.
  - 5 calls with STACK_DEPTH=4 -> stack_err = 1.
  - ret on empty stack -> stack_err = 1 and PC increments.
- Async reset mid-run: pull rst_n low between edges at PC 0x37 -> current becomes 0x00 immediately, stack_err = 0.
